rvc_asap_5pl_vga_scan: RTL and testbench

- VGA scan-out engine sitting directly downstream of the VGA frame memory that the rvc_asap_5pl core writes through its memory wrapper.
- Generates 640x480@60 timing from the 50 MHz core Clock using a /2 pixel enable.
- Fetches one frame-buffer byte per 8 pixels over a 1-cycle-latency read port, serializes it as monochrome pixels, and drives RED/GREEN/BLUE, h_sync and v_sync.
- Memory byte layout is the one used by the end-of-test screen dump.

---
 rtl/rvc_asap_5pl_vga_scan.sv | 133 +++++++++++++
 tb/tb_rvc_asap_5pl_vga_scan.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rvc_asap_5pl_vga_scan.sv
// rtl/rvc_asap_5pl_vga_scan.sv - 640x480@60 monochrome VGA scan-out with one-byte-ahead frame-buffer prefetch
module rvc_asap_5pl_vga_scan #(
    parameter logic [15:0] VGA_MEM_OFFSET = 16'h3000,
    parameter int          H_VISIBLE      = 640,
    parameter int          H_SYNC_START   = 656,
    parameter int          H_SYNC_END     = 751,
    parameter int          H_TOTAL        = 800,
    parameter int          V_VISIBLE      = 480,
    parameter int          V_SYNC_START   = 490,
    parameter int          V_SYNC_END     = 491,
    parameter int          V_TOTAL        = 525
) (
    input  logic        Clock,
    input  logic        Rst,
    output logic        RdEn,
    output logic [15:0] RdAddr,
    input  logic [7:0]  RdData,
    output logic [3:0]  RED,
    output logic [3:0]  GREEN,
    output logic [3:0]  BLUE,
    output logic        h_sync,
    output logic        v_sync
);

    localparam logic [9:0] H_VIS   = 10'(H_VISIBLE);
    localparam logic [9:0] H_FETCH = 10'(H_VISIBLE - 8);
    localparam logic [9:0] HS_LO   = 10'(H_SYNC_START);
    localparam logic [9:0] HS_HI   = 10'(H_SYNC_END);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_VIS   = 10'(V_VISIBLE);
    localparam logic [9:0] VS_LO   = 10'(V_SYNC_START);
    localparam logic [9:0] VS_HI   = 10'(V_SYNC_END);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);

    logic        pix_en_q, pix_en_d;
    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [7:0]  cur_byte_q, cur_byte_d;
    logic [7:0]  next_byte_q, next_byte_d;
    logic        rd_en_q, rd_en_d;
    logic [15:0] rd_addr_q, rd_addr_d;
    logic        pix_q, pix_d;
    logic        h_sync_q, h_sync_d;
    logic        v_sync_q, v_sync_d;

    logic        visible;
    logic        line_end;
    logic        pix_bit;
    logic [9:0]  next_row;

    // Four consecutive rows share one 320-byte group; 320 = 256 + 64.
    function automatic logic [15:0] byte_addr(input logic [9:0] row, input logic [6:0] col);
        logic [15:0] grp;
        grp = {8'd0, row[9:2]};
        return VGA_MEM_OFFSET + (grp << 8) + (grp << 6) + {7'd0, col, 2'b00} + {14'd0, row[1:0]};
    endfunction

    always_comb begin
        visible  = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        line_end = (h_cnt_q == H_LAST);
        next_row = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        pix_bit  = (h_cnt_q[2:0] == 3'd0) ? next_byte_q[0] : cur_byte_q[h_cnt_q[2:0]];

        pix_en_d    = ~pix_en_q;
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        cur_byte_d  = cur_byte_q;
        next_byte_d = rd_en_q ? RdData : next_byte_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        pix_d       = pix_q;
        h_sync_d    = h_sync_q;
        v_sync_d    = v_sync_q;

        if (pix_en_q) begin
            h_cnt_d  = line_end ? 10'd0 : h_cnt_q + 10'd1;
            if (line_end) begin
                v_cnt_d = next_row;
            end
            h_sync_d = !((h_cnt_q >= HS_LO) && (h_cnt_q <= HS_HI));
            v_sync_d = !((v_cnt_q >= VS_LO) && (v_cnt_q <= VS_HI));
            pix_d    = visible && pix_bit;

            // The byte for this column is consumed while the next one is requested.
            if (visible && (h_cnt_q[2:0] == 3'd0)) begin
                cur_byte_d = next_byte_q;
                if (h_cnt_q < H_FETCH) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = byte_addr(v_cnt_q, h_cnt_q[9:3] + 7'd1);
                end
            end
            if (line_end && (next_row < V_VIS)) begin
                rd_en_d   = 1'b1;
                rd_addr_d = byte_addr(next_row, 7'd0);
            end
        end
    end

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            pix_en_q    <= 1'b0;
            h_cnt_q     <= 10'd0;
            v_cnt_q     <= 10'd0;
            cur_byte_q  <= 8'd0;
            next_byte_q <= 8'd0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= 16'd0;
            pix_q       <= 1'b0;
            h_sync_q    <= 1'b1;
            v_sync_q    <= 1'b1;
        end else begin
            pix_en_q    <= pix_en_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            cur_byte_q  <= cur_byte_d;
            next_byte_q <= next_byte_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            pix_q       <= pix_d;
            h_sync_q    <= h_sync_d;
            v_sync_q    <= v_sync_d;
        end
    end

    assign RdEn   = rd_en_q;
    assign RdAddr = rd_addr_q;
    assign RED    = {4{pix_q}};
    assign GREEN  = {4{pix_q}};
    assign BLUE   = {4{pix_q}};
    assign h_sync = h_sync_q;
    assign v_sync = v_sync_q;

endmodule

// File: tb/tb_rvc_asap_5pl_vga_scan.sv
// tb/tb_rvc_asap_5pl_vga_scan.sv - scoreboard bench for the VGA scan-out engine (shortened frame)
module tb_rvc_asap_5pl_vga_scan;

    localparam int HT = 800;
    localparam int VV = 6;
    localparam int VT = 11;
    localparam int FR = HT * VT;

    logic        Clock = 1'b0;
    logic        Rst   = 1'b0;
    logic        RdEn;
    logic [15:0] RdAddr;
    logic [7:0]  RdData = 8'h00;
    logic [3:0]  RED, GREEN, BLUE;
    logic        h_sync, v_sync;

    int errors = 0;
    int checks = 0;
    int ncyc;
    int hs_low = 0;

    // kind: 0 rgb, 1 h_sync, 2 v_sync, 3 fetch with address, 4 no fetch
    typedef struct { int p; int kind; int val; } chk_t;
    typedef struct { int p; int addr; } fetch_t;
    chk_t   cq[$];
    fetch_t fq[$];

    int pat_row1[8] = '{0, 0, 15, 15, 15, 15, 0, 0};
    int pat_row0[8] = '{15, 0, 15, 0, 0, 15, 0, 15};

    always #10 Clock = ~Clock;

    rvc_asap_5pl_vga_scan #(
        .V_VISIBLE   (VV),
        .V_SYNC_START(8),
        .V_SYNC_END  (9),
        .V_TOTAL     (VT)
    ) dut (
        .Clock (Clock),
        .Rst   (Rst),
        .RdEn  (RdEn),
        .RdAddr(RdAddr),
        .RdData(RdData),
        .RED   (RED),
        .GREEN (GREEN),
        .BLUE  (BLUE),
        .h_sync(h_sync),
        .v_sync(v_sync)
    );

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        if (a == 16'h3000) return 8'hA5;
        if (a == 16'h3001) return 8'h3C;
        return 8'hFF;
    endfunction

    always @(negedge Clock) RdData <= RdEn ? mem_byte(RdAddr) : 8'h00;

    function automatic int exp_addr(input int r, input int c);
        return 'h3000 + (r / 4) * 320 + c * 4 + (r % 4);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rden"}, int'(RdEn), 0);
        check({tag, "_rdaddr"}, int'(RdAddr), 0);
        check({tag, "_rgb"}, int'({RED, GREEN, BLUE}), 0);
        check({tag, "_hsync"}, int'(h_sync), 1);
        check({tag, "_vsync"}, int'(v_sync), 1);
    endtask

    task automatic add_chk(input int p, input int kind, input int val);
        chk_t c;
        int   i;
        c.p = p; c.kind = kind; c.val = val;
        i = 0;
        while (i < cq.size() && cq[i].p <= p) i++;
        cq.insert(i, c);
    endtask

    task automatic build_fetches(input int lo, input int hi);
        fetch_t f;
        int h, v, r;
        for (int p = lo; p <= hi; p++) begin
            h = p % HT;
            v = (p / HT) % VT;
            if (v < VV && h % 8 == 0 && h < 632) begin
                f.p = p; f.addr = exp_addr(v, h / 8 + 1);
                fq.push_back(f);
            end
            if (h == HT - 1) begin
                r = (v == VT - 1) ? 0 : v + 1;
                if (r < VV) begin
                    f.p = p; f.addr = exp_addr(r, 0);
                    fq.push_back(f);
                end
            end
        end
    endtask

    always @(posedge Clock or negedge Rst) begin
        if (!Rst) ncyc <= 0;
        else      ncyc <= ncyc + 1;
    end

    always @(negedge Clock) begin : monitor
        int     p;
        fetch_t f;
        chk_t   c;
        if (Rst) begin
            p = (ncyc >= 2 && ncyc % 2 == 0) ? ncyc / 2 - 1 : -1;
            if (!h_sync) hs_low++;
            if (RdEn) begin
                if (fq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fetch_extra: got addr %0h at cycle %0d expected no fetch", RdAddr, ncyc);
                end else begin
                    f = fq.pop_front();
                    check($sformatf("fetch_pixel@%0d", f.p), p, f.p);
                    check($sformatf("fetch_addr@%0d", f.p), int'(RdAddr), f.addr);
                end
            end
            if (p >= 0) begin
                while (cq.size() > 0 && cq[0].p <= p) begin
                    c = cq.pop_front();
                    case (c.kind)
                        0: check($sformatf("rgb@%0d", c.p), int'({RED, GREEN, BLUE}), c.val * 'h111);
                        1: check($sformatf("hsync@%0d", c.p), int'(h_sync), c.val);
                        2: check($sformatf("vsync@%0d", c.p), int'(v_sync), c.val);
                        3: check($sformatf("rdaddr@%0d", c.p), RdEn ? int'(RdAddr) : -1, c.val);
                        default: check($sformatf("rden@%0d", c.p), int'(RdEn), 0);
                    endcase
                end
            end
        end
    end

    initial begin
        Rst = 1'b0;
        repeat (4) @(posedge Clock);
        @(negedge Clock);
        check_reset("reset");

        build_fetches(0, 10700);
        add_chk(0, 0, 0);   add_chk(7, 0, 0);   add_chk(8, 0, 15);
        add_chk(639, 0, 15); add_chk(640, 0, 0);
        for (int x = 0; x < 8; x++) add_chk(HT + x, 0, pat_row1[x]);
        add_chk(4800, 0, 0);
        for (int x = 0; x < 8; x++) add_chk(FR + x, 0, pat_row0[x]);
        for (int x = 8; x < 16; x++) add_chk(FR + x, 0, 15);
        add_chk(FR + 640, 0, 0); add_chk(FR + 799, 0, 0);
        add_chk(10700, 0, 15);
        for (int l = 0; l < 2; l++) begin
            add_chk(l * HT + 655, 1, 1); add_chk(l * HT + 656, 1, 0);
            add_chk(l * HT + 751, 1, 0); add_chk(l * HT + 752, 1, 1);
        end
        add_chk(5600, 2, 1); add_chk(6400, 2, 0); add_chk(7999, 2, 0); add_chk(8000, 2, 1);
        add_chk(0, 3, 'h3004);    add_chk(799, 3, 'h3001);
        add_chk(4016, 3, 'h314D); add_chk(4624, 3, 'h327D);
        add_chk(4632, 4, 0);      add_chk(4799, 4, 0);
        add_chk(8799, 3, 'h3000);

        hs_low = 0;
        Rst = 1'b1;
        repeat (3300) @(posedge Clock);
        @(negedge Clock);
        #1;
        check("hsync_low_clocks", hs_low, 384);

        repeat (21402 - 3300) @(posedge Clock);
        @(negedge Clock);
        #1;
        check("fetches_left_before_reset", fq.size(), 0);
        check("checks_left_before_reset", cq.size(), 0);
        Rst = 1'b0;
        #1;
        check_reset("midframe");
        fq.delete();
        cq.delete();

        repeat (3) @(posedge Clock);
        @(negedge Clock);
        build_fetches(0, 1049);
        add_chk(0, 3, 'h3004);
        add_chk(0, 0, 0);
        add_chk(8, 0, 15);
        Rst = 1'b1;
        repeat (2100) @(posedge Clock);
        @(negedge Clock);
        #1;
        check("fetches_left_at_end", fq.size(), 0);
        check("checks_left_at_end", cq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
